// File: rtl/selector_seq.sv
// Stimulus sequencer for a 2-bit-select / two-input selector: steps all 16 combinations, captures Q, flags Q==NQ.
// Optional pass/fail output against the golden table when SELSEQ_CHECK_EN is defined.
module selector_seq #(
   parameter int DWELL = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        q_in,
   input  logic        nq_in,
   output logic [1:0]  sel,
   output logic        a,
   output logic        b,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic        err
`ifdef SELSEQ_CHECK_EN
   ,
   output logic        pass
`endif
);

   generate
      if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
         $error("selector_seq: DWELL must be in 1..255");
      end
   endgenerate

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);
   localparam logic [15:0] GOLDEN_TT  = 16'hE8AC;

   logic [1:0]  state_reg, state_next;
   logic [3:0]  idx_reg, idx_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [15:0] tt_reg, tt_next;
   logic        err_reg, err_next;
   logic        drive_on;
   logic        run_abort;

   assign run_abort = abort && (state_reg == S_DRIVE || state_reg == S_SAMPLE);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      tt_next    = tt_reg;
      err_next   = err_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               tt_next    = '0;
               err_next   = 1'b0;
               idx_next   = '0;
               cnt_next   = '0;
               state_next = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (abort) begin
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
               if (cnt_reg == DWELL_LAST) begin
                  state_next = S_SAMPLE;
               end
            end
         end
         S_SAMPLE: begin
            // abort wins over the capture so a partial table never gets the aborted sample
            if (abort) begin
               state_next = S_IDLE;
            end else begin
               tt_next[idx_reg] = q_in;
               err_next         = err_reg | (q_in == nq_in);
               if (idx_reg == 4'd15) begin
                  state_next = S_DONE;
               end else begin
                  idx_next   = idx_reg + 4'd1;
                  cnt_next   = '0;
                  state_next = S_DRIVE;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   assign drive_on = (state_next == S_DRIVE) || (state_next == S_SAMPLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         tt_reg    <= '0;
         err_reg   <= 1'b0;
         sel       <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         tt_reg    <= tt_next;
         err_reg   <= err_next;
         sel       <= drive_on ? idx_next[3:2] : 2'b00;
         a         <= drive_on ? idx_next[1]   : 1'b0;
         b         <= drive_on ? idx_next[0]   : 1'b0;
         busy      <= drive_on;
         done      <= (state_next == S_DONE);
      end
   end

   assign tt  = tt_reg;
   assign err = err_reg;

`ifdef SELSEQ_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass <= 1'b0;
      end else if (state_next == S_DONE && state_reg == S_SAMPLE) begin
         pass <= (tt_next == GOLDEN_TT) && !err_next;
      end else if ((state_reg == S_IDLE && start) || run_abort) begin
         pass <= 1'b0;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = run_abort ^ (GOLDEN_TT == 16'h0);
`endif

endmodule

// File: tb/tb_selector_seq.sv
// Scoreboard bench for selector_seq: each run pushes its expected outcome; a monitor checks it when busy falls.
// Exercises SELSEQ_CHECK_EN's pass output when that macro is defined.
module tb_selector_seq;

   localparam int DW = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        q_in;
   logic        nq_in;
   logic [1:0]  sel;
   logic        a;
   logic        b;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic        err;
`ifdef SELSEQ_CHECK_EN
   logic        pass;
`endif

   logic fault_en;
   logic stuck;

   always #5 clk = ~clk;

   selector_seq #(.DWELL(DW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .q_in  (q_in),
      .nq_in (nq_in),
      .sel   (sel),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .tt    (tt),
      .err   (err)
`ifdef SELSEQ_CHECK_EN
      ,
      .pass  (pass)
`endif
   );

   // Behavioural selector: 00 a, 01 b, 10 a&b, 11 a|b; optional faults
   always_comb begin
      q_in  = 1'b0;
      nq_in = 1'b1;
      if (!stuck) begin
         case (sel)
            2'b00:   q_in = a;
            2'b01:   q_in = b;
            2'b10:   q_in = a & b;
            default: q_in = a | b;
         endcase
         nq_in = ~q_in;
         if (fault_en && {sel, a, b} == 4'd9) nq_in = q_in;
      end
   end

   typedef struct {
      string       name;
      logic [15:0] tt;
      logic        err;
      logic        done;
      int          busy_cycles;
      logic        pass;
   } rec_t;

   rec_t sb[$];
   int checks = 0;
   int passes = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_end(input string name);
      for (int i = 0; i < 300 && busy; i++) tick(1);
      if (busy) begin
         checks++;
         $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
      end
      tick(2);
   endtask

   function automatic rec_t mk(input string n, input logic [15:0] t, input logic e,
                               input logic d, input int bc, input logic p);
      rec_t r;
      r.name = n; r.tt = t; r.err = e; r.done = d; r.busy_cycles = bc; r.pass = p;
      return r;
   endfunction

   // Monitor: counts busy cycles, checks the sel/a/b stepping, scores the run when busy drops
   initial begin
      int   bc;
      bit   prev_busy;
      bit   seq_ok;
      rec_t r;
      bc = 0; prev_busy = 0; seq_ok = 1;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (busy) begin
            if ({sel, a, b} != 4'(bc / (DW + 1))) seq_ok = 0;
            bc++;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL sb_underflow: got run end expected none");
            end else begin
               r = sb.pop_front();
               chk({r.name, "_tt"},   32'(tt),   32'(r.tt));
               chk({r.name, "_err"},  32'(err),  32'(r.err));
               chk({r.name, "_done"}, 32'(done), 32'(r.done));
               chk({r.name, "_busy"}, 32'(bc),   32'(r.busy_cycles));
               chk({r.name, "_seq"},  32'(seq_ok), 32'd1);
`ifdef SELSEQ_CHECK_EN
               chk({r.name, "_pass"}, 32'(pass), 32'(r.pass));
`endif
               $display("run %s: busy=%0d tt=%h err=%0d done=%0d", r.name, bc, tt, err, done);
            end
            bc = 0;
            seq_ok = 1;
         end
         prev_busy = busy;
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault_en = 1'b0; stuck = 1'b0;
      tick(2);
      chk("reset_outs", 32'({sel, a, b, busy, done, err}), 32'd0);
      chk("reset_tt", 32'(tt), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Async reset while driving idx 5
      sb.push_back(mk("reset_mid", 16'h0000, 1'b0, 1'b0, 15, 1'b0));
      start = 1'b1; tick(1); start = 1'b0;
      tick(15);
      chk("pre_rst_idx", 32'({sel, a, b}), 32'd5);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'({sel, a, b, busy, done, err}), 32'd0);
      chk("async_rst_tt", 32'(tt), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("idle_after_rst", 32'(busy), 32'd0);

      // Full run, correct selector
      sb.push_back(mk("full", 16'hE8AC, 1'b0, 1'b1, 48, 1'b1));
      start = 1'b1; tick(1); start = 1'b0;
      wait_end("full");
      chk("tt_hold_idle", 32'(tt), 32'hE8AC);
`ifdef SELSEQ_CHECK_EN
      chk("pass_hold_idle", 32'(pass), 32'd1);
`endif

      // Abort during SAMPLE of idx 6
      sb.push_back(mk("abort6", 16'h002C, 1'b0, 1'b0, 21, 1'b0));
      start = 1'b1; tick(1); start = 1'b0;
      tick(20);
      abort = 1'b1; tick(1); abort = 1'b0;
      chk("abort_idle", 32'(busy), 32'd0);
      tick(3);

      // NQ==Q at idx 9, with start pulses while busy and in DONE
      fault_en = 1'b1;
      sb.push_back(mk("fault9", 16'hE8AC, 1'b1, 1'b1, 48, 1'b0));
      start = 1'b1; tick(1); start = 1'b0;
      tick(9);
      start = 1'b1; tick(1); start = 1'b0;
      tick(9);
      chk("err_before9", 32'(err), 32'd0);
      tick(20);
      chk("err_after9", 32'(err), 32'd1);
      tick(9);
      chk("done_cycle", 32'(done), 32'd1);
      start = 1'b1; tick(1); start = 1'b0;
      chk("no_restart", 32'(busy), 32'd0);
      fault_en = 1'b0;

      // New start two cycles after done clears tt and err
      tick(1);
      sb.push_back(mk("rerun", 16'hE8AC, 1'b0, 1'b1, 48, 1'b1));
      start = 1'b1; tick(1); start = 1'b0;
      chk("rerun_cleared", 32'({tt, err}), 32'd0);
      wait_end("rerun");

      // Stuck Q; start and abort together in IDLE, start wins
      stuck = 1'b1;
      sb.push_back(mk("stuck", 16'h0000, 1'b0, 1'b1, 48, 1'b0));
      start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
      wait_end("stuck");
      stuck = 1'b0;

      tick(5);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd4);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/selector_seq.md
Name: selector_seq

Overview:
Upstream stimulus sequencer for the 2-bit-select/two-input selector stage (sel, a, b in; Q, NQ out). On a start request it steps sel/a/b through all 16 combinations, holds each for a programmable dwell time, and samples the selector's Q/NQ back. It builds a 16-bit captured truth table and a sticky complement-error flag. It sits between control logic and the selector in self-test and characterisation setups.

Parameters:
DWELL, 4, drive cycles per combination before sampling; legal range 1..255, elaboration error outside that range.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled in IDLE only
abort  input  1  terminates a run in progress
q_in  input  1  selector Q
nq_in  input  1  selector NQ
sel  output  2  selector select, registered
a  output  1  selector input a, registered
b  output  1  selector input b, registered
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when a run completes
tt  output  16  captured truth table; bit idx = Q sampled for combination idx
err  output  1  sticky; set if q_in == nq_in at any sample point

Behaviour:
- Reset (async, rst_n=0): state IDLE; sel=0, a=0, b=0, busy=0, done=0, tt=0, err=0, idx=0, dwell counter=0. Release is synchronous to the next clk edge.
- Combination mapping: 4-bit idx; sel=idx[3:2], a=idx[1], b=idx[0]. All outputs are registered, with no combinational path from inputs to outputs.
- FSM states:
  - IDLE: sel/a/b=0, busy=0. If start=1, then at the next edge: tt=0, err=0, idx=0, cnt=0, go to DRIVE.
  - DRIVE: outputs show idx, busy=1. cnt increments each cycle. When cnt==DWELL-1, go to SAMPLE.
  - SAMPLE: outputs still show idx, busy=1. At the edge ending this cycle:
    - tt[idx] <= q_in; err <= err | (q_in == nq_in).
    - If idx==15, go to DONE. Otherwise idx+1, cnt=0, go to DRIVE.
  - DONE: one cycle. done=1, busy=0, sel/a/b=0. Then go to IDLE.
- Latency:
  - Each combination is driven for DWELL+1 cycles and sampled on its last edge.
  - busy is high for exactly 16*(DWELL+1) cycles, starting the cycle after start is accepted.
  - done is high the cycle immediately after the last busy cycle.
- start while busy or in DONE: ignored, no restart.
- abort in DRIVE or SAMPLE: go to IDLE at the next edge. No done pulse, no sample that cycle, tt/err keep their partial values. abort has priority over a simultaneous SAMPLE capture. abort in IDLE or DONE: no effect.
- start and abort both high in IDLE: start wins; abort is only honoured from the next cycle on.
- idx wrap: idx never passes 15; the run terminates via DONE.
- Reset mid-run: immediate return to reset values. tt and err are cleared.
- tt and err hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro: SELSEQ_CHECK_EN.
- When defined:
  - Extra output port pass (1 bit), registered, reset 0.
  - pass is set in the DONE cycle to (tt_final == 16'hE8AC) && !err, where tt_final includes the idx-15 capture. 16'hE8AC is the golden table: sel 00 Q=a, 01 Q=b, 10 Q=a&b, 11 Q=a|b.
  - pass holds until the next accepted start (cleared then), an abort, or reset.
- When undefined: the pass port and its logic are absent.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE at idx=5 -> all outputs 0 immediately (async); after release, state is IDLE and busy=0.
- Full run, DWELL=2, correct selector model attached: pulse start -> busy high 48 cycles, sel/a/b step 0..15 every 3 cycles, done pulse at cycle 49, tt=16'hE8AC, err=0 (pass=1 with SELSEQ_CHECK_EN).
- Fault injection, DWELL=2: NQ forced equal to Q for combination idx 9 -> err=1 sticky after the idx-9 sample; tt=16'hE8AC; pass=0.
- Stuck Q, DWELL=1: q_in tied 0, nq_in tied 1 -> tt=16'h0000, err=0, done after 32 busy cycles.
- Abort, DWELL=4: abort asserted during SAMPLE of idx 6 -> IDLE next cycle, no done pulse, tt bits 0..5 captured, bit 6 and above 0.
- start pulses during busy and in the DONE cycle -> no restart; a start issued 2 cycles after done -> new run clears tt and err.
